shuff_token_seq: RTL

Sequencer for the GZIP static-Huffman (BTYPE=01) encoder back end. Accepts LZ77 tokens (literal, length/distance match, end-of-block) over a valid/ready handshake and encodes literals internally. For matches, it drives the registered static length encoder (`slength`) and the registered static distance encoder. It then emits one symbol per output beat, in DEFLATE order, to the downstream bit packer.

---
 rtl/shuff_pkg.sv | 30 +++
 rtl/shuff_literal_enc.sv | 21 ++
 rtl/shuff_token_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/shuff_pkg.sv
// rtl/shuff_pkg.sv - shared types and DEFLATE static-Huffman constants; SHUFF_BLOCK_HDR_EN adds the header state
package shuff_pkg;

`ifdef SHUFF_BLOCK_HDR_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LEN, ST_DIST, ST_HDR} state_t;
  localparam state_t ST_RESET = ST_HDR;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_LEN, ST_DIST} state_t;
  localparam state_t ST_RESET = ST_IDLE;
`endif

  // out_type codes; the packer picks bit order from these
  localparam logic [1:0] OT_LIT  = 2'd0;
  localparam logic [1:0] OT_LEN  = 2'd1;
  localparam logic [1:0] OT_DIST = 2'd2;
  localparam logic [1:0] OT_HDR  = 2'd3;

  // end-of-block is symbol 256: 7-bit code 0000000
  localparam logic [6:0] EOB_CODE = 7'd0;
  localparam logic [4:0] EOB_BITS = 5'd7;

  // literals 0..143 use 8-bit codes from 0x30, 144..255 use 9-bit codes from 0x190
  localparam logic [8:0] LIT_BASE_LO = 9'h030;
  localparam logic [8:0] LIT_BASE_HI = 9'h190;
  localparam logic [7:0] LIT_SPLIT   = 8'd143;

  localparam logic [1:0] BTYPE_STATIC = 2'b01;
  localparam logic [4:0] HDR_BITS     = 5'd3;

endpackage

// File: rtl/shuff_literal_enc.sv
// rtl/shuff_literal_enc.sv - combinational static-Huffman literal encoder
module shuff_literal_enc
  import shuff_pkg::*;
(
  input  logic [7:0] lit,
  output logic [8:0] code,
  output logic [3:0] width
);

  // two code ranges split at 143; the upper range is one bit wider
  always_comb begin
    if (lit <= LIT_SPLIT) begin
      code  = LIT_BASE_LO + {1'b0, lit};
      width = 4'd8;
    end else begin
      code  = LIT_BASE_HI + {1'b0, lit} - 9'd144;
      width = 4'd9;
    end
  end

endmodule

// File: rtl/shuff_token_seq.sv
// rtl/shuff_token_seq.sv - LZ77 token to static-Huffman symbol sequencer; block header beats under SHUFF_BLOCK_HDR_EN
module shuff_token_seq
  import shuff_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tok_valid,
  output logic        tok_ready,
  input  logic        tok_is_match,
  input  logic        tok_eob,
  input  logic [7:0]  tok_literal,
  input  logic [8:0]  tok_length,
  input  logic [14:0] tok_distance,
  input  logic        blk_final,
  output logic [8:0]  enc_len_out,
  input  logic [12:0] enc_len_code_in,
  input  logic [3:0]  enc_len_bits_in,
  output logic [14:0] enc_dist_out,
  input  logic [17:0] enc_dist_code_in,
  input  logic [4:0]  enc_dist_bits_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_data,
  output logic [4:0]  out_bits,
  output logic [1:0]  out_type
);

  state_t      state_q, state_d;
  logic        slot_free;
  logic        hdr_hold;
  logic        ld;
  logic [17:0] ld_data;
  logic [4:0]  ld_bits;
  logic [1:0]  ld_type;
  logic        match_fire;
  logic [8:0]  lit_code;
  logic [3:0]  lit_width;

  shuff_literal_enc u_lit (
    .lit   (tok_literal),
    .code  (lit_code),
    .width (lit_width)
  );

  assign slot_free = !out_valid | out_ready;

`ifdef SHUFF_BLOCK_HDR_EN
  logic hdr_pend_q;
  logic hdr_set;
  logic hdr_clr;
  assign hdr_hold = hdr_pend_q;
`else
  logic unused_blk_final;
  assign unused_blk_final = blk_final;
  assign hdr_hold = 1'b0;
`endif

  // reset gating keeps the handshake closed while rst_n is low
  assign tok_ready = rst_n & slot_free & (state_q == ST_IDLE) & !hdr_hold;

  // next state and output-slot load selection
  always_comb begin
    state_d    = state_q;
    ld         = 1'b0;
    ld_data    = '0;
    ld_bits    = '0;
    ld_type    = OT_LIT;
    match_fire = 1'b0;
`ifdef SHUFF_BLOCK_HDR_EN
    hdr_set    = 1'b0;
    hdr_clr    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef SHUFF_BLOCK_HDR_EN
        if (hdr_pend_q) state_d = ST_HDR;
`endif
        if (tok_valid && tok_ready) begin
          if (tok_eob) begin
            ld      = 1'b1;
            ld_data = {11'b0, EOB_CODE};
            ld_bits = EOB_BITS;
`ifdef SHUFF_BLOCK_HDR_EN
            hdr_set = 1'b1;
`endif
          end else if (tok_is_match) begin
            match_fire = 1'b1;
            state_d    = ST_WAIT;
          end else begin
            ld      = 1'b1;
            ld_data = {9'b0, lit_code};
            ld_bits = {1'b0, lit_width};
          end
        end
      end
      ST_WAIT: state_d = ST_LEN;
      ST_LEN: begin
        if (slot_free) begin
          ld      = 1'b1;
          ld_data = {5'b0, enc_len_code_in};
          ld_bits = {1'b0, enc_len_bits_in};
          ld_type = OT_LEN;
          state_d = ST_DIST;
        end
      end
      ST_DIST: begin
        if (slot_free) begin
          ld      = 1'b1;
          ld_data = enc_dist_code_in;
          ld_bits = enc_dist_bits_in;
          ld_type = OT_DIST;
          state_d = ST_IDLE;
        end
      end
`ifdef SHUFF_BLOCK_HDR_EN
      ST_HDR: begin
        if (slot_free) begin
          ld      = 1'b1;
          ld_data = {15'b0, BTYPE_STATIC, blk_final};
          ld_bits = HDR_BITS;
          ld_type = OT_HDR;
          hdr_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // output slot: loads only when free, otherwise holds until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bits  <= '0;
      out_type  <= OT_LIT;
    end else if (ld) begin
      out_valid <= 1'b1;
      out_data  <= ld_data;
      out_bits  <= ld_bits;
      out_type  <= ld_type;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // encoder operands hold from match acceptance so stalled beats stay valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_len_out  <= '0;
      enc_dist_out <= '0;
    end else if (match_fire) begin
      enc_len_out  <= tok_length;
      enc_dist_out <= tok_distance;
    end
  end

`ifdef SHUFF_BLOCK_HDR_EN
  // header-pending flag: set by reset and each EOB, cleared when the header is emitted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       hdr_pend_q <= 1'b1;
    else if (hdr_set) hdr_pend_q <= 1'b1;
    else if (hdr_clr) hdr_pend_q <= 1'b0;
  end
`endif

endmodule
